// File: rtl/bch_pkg.sv
// Shared BCH(141,127) constants and encoder state encoding.
package bch_pkg;

  localparam int unsigned K    = 127;
  localparam int unsigned P    = 14;
  localparam int unsigned N    = K + P;
  localparam int unsigned KPAD = 128;

  // g(x) = (x^7+x^3+1)(x^7+x^3+x^2+x+1); x^14 term implicit.
  localparam logic [P-1:0] BCH_GEN_POLY = 14'h0377;
  // Parity of data bit 0, i.e. x^14 mod g(x).
  localparam logic [P-1:0] BCH_SEED     = 14'h0377;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bch_lfsr_step.sv
// Combinational CHUNK-step parity update, highest input bit absorbed first.
module bch_lfsr_step
  import bch_pkg::*;
#(
  parameter int unsigned CHUNK = 8
) (
  input  logic [P-1:0]     r_i,
  input  logic [CHUNK-1:0] bits_i,
  output logic [P-1:0]     r_next_c_o
);

  // Unrolled Horner steps: multiply by x, reduce on the bit leaving [13], add SEED per set bit.
  always_comb begin
    logic [P-1:0] r;
    r = r_i;
    for (int j = int'(CHUNK) - 1; j >= 0; j--) begin
      r = {r[P-2:0], 1'b0}
          ^ (r[P-1]    ? BCH_GEN_POLY : '0)
          ^ (bits_i[j] ? BCH_SEED     : '0);
    end
    r_next_c_o = r;
  end

endmodule

// File: rtl/bch_enc_seq.sv
// Sequential systematic BCH encoder: 127-bit message in, {parity, message} out.
module bch_enc_seq
  import bch_pkg::*;
#(
  parameter int unsigned CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_code,
  output logic         busy
);

  localparam int unsigned NSTEP = KPAD / CHUNK;
  localparam int unsigned CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

  state_e          state_q, state_d;
  logic [K-1:0]    msg_q, msg_d;
  logic [KPAD-1:0] sr_q, sr_d;
  logic [P-1:0]    r_q, r_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic [N-1:0]    code_q, code_d;
  logic [P-1:0]    r_next_c;

  bch_lfsr_step #(.CHUNK(CHUNK)) u_step (
    .r_i        (r_q),
    .bits_i     (sr_q[KPAD-1 -: CHUNK]),
    .r_next_c_o (r_next_c)
  );

  // State and datapath registers; reset discards any partial parity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      msg_q       <= '0;
      sr_q        <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      code_q      <= '0;
    end else begin
      state_q     <= state_d;
      msg_q       <= msg_d;
      sr_q        <= sr_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      code_q      <= code_d;
    end
  end

  // Next-state: accept in IDLE, absorb CHUNK bits per cycle in SHIFT, hold codeword in DONE.
  always_comb begin
    state_d     = state_q;
    msg_d       = msg_q;
    sr_d        = sr_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    code_d      = code_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          msg_d      = in_data;
          sr_d       = {1'b0, in_data};
          r_d        = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        r_d   = r_next_c;
        sr_d  = sr_q << CHUNK;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          code_d      = {r_next_c, msg_q};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_code  = code_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bch_enc_seq.sv
// Directed bench for bch_enc_seq at the default CHUNK of 8.
module tb_bch_enc_seq;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [126:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [140:0] out_code;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  bch_enc_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [140:0] obs, input logic [140:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Parity as the sum of x^i * SEED mod g(x) over set bits, computed LSB upward.
  function automatic logic [13:0] model_par(input logic [126:0] m);
    logic [13:0] acc;
    logic [13:0] t;
    acc = '0;
    t   = 14'h0377;
    for (int i = 0; i < 127; i++) begin
      if (m[i]) acc ^= t;
      t = {t[12:0], 1'b0} ^ (t[13] ? 14'h0377 : 14'h0000);
    end
    return acc;
  endfunction

  task automatic start_msg(input logic [126:0] m);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_wait", 141'(in_ready), 141'(1));
    in_valid = 1'b1;
    in_data  = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Counts edges after the accepting edge until out_valid; optionally pulses in_valid mid-SHIFT.
  task automatic wait_valid(input int pulse_at, output int lat);
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      if (lat == 5) check("busy_shift", 141'(busy), 141'(1));
      if (lat == pulse_at) begin
        check("in_ready_shift", 141'(in_ready), 141'(0));
        in_valid = 1'b1;
        in_data  = 127'h5;
      end else if (lat == pulse_at + 1) begin
        in_valid = 1'b0;
        in_data  = '0;
      end
      if (out_valid) break;
      lat++;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic run_one(input string tag, input logic [126:0] m, input logic [13:0] par,
                         input int pulse_at);
    int lat;
    start_msg(m);
    wait_valid(pulse_at, lat);
    check({tag, "_lat"},  141'(lat), 141'(16));
    check({tag, "_par"},  141'(out_code[140:127]), 141'(par));
    check({tag, "_data"}, 141'(out_code[126:0]), 141'(m));
  endtask

  initial begin
    int extra;
    int bad;
    logic [126:0] m;
    logic [13:0]  dir_par [5];
    logic [126:0] dir_msg [5];

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  141'(in_ready),  141'(1));
    check("rst_out_valid", 141'(out_valid), 141'(0));
    check("rst_busy",      141'(busy),      141'(0));
    check("rst_out_code",  out_code,        141'(0));
    rst = 1'b0;

    run_one("m1", 127'd1, 14'h0377, -1);

    dir_msg = '{127'd2, 127'd3, 127'd4, 127'd8, 127'd9};
    dir_par = '{14'h06EE, 14'h0599, 14'h0DDC, 14'h1BB8, 14'h18CF};
    for (int i = 0; i < 5; i++) run_one($sformatf("dir%0d", i), dir_msg[i], dir_par[i], -1);

    // All-zero message with an in_valid pulse during SHIFT that must be ignored.
    run_one("zero", 127'd0, 14'h0000, 3);
    check("zero_code", out_code, 141'(0));
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("zero_extra", 141'(extra), 141'(0));
    check("zero_idle_ready", 141'(in_ready), 141'(1));

    // Backpressure: codeword held while out_ready is low.
    out_ready = 1'b0;
    run_one("bp", 127'd8, 14'h1BB8, -1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_code !== {14'h1BB8, 127'd8} || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    check("bp_hold", 141'(bad), 141'(0));
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 141'(out_valid), 141'(0));
    check("bp_release_ready", 141'(in_ready),  141'(1));

    // Reset in the middle of SHIFT discards the message.
    start_msg(127'd3);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 141'(out_valid), 141'(0));
    check("midrst_in_ready",  141'(in_ready),  141'(1));
    check("midrst_busy",      141'(busy),      141'(0));
    check("midrst_code",      out_code,        141'(0));
    rst = 1'b0;
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("midrst_extra", 141'(extra), 141'(0));
    run_one("after_rst", 127'd9, 14'h18CF, -1);

    // Random messages against the column-sum model.
    for (int i = 0; i < 20; i++) begin
      m = 127'({$urandom, $urandom, $urandom, $urandom});
      run_one($sformatf("rnd%0d", i), m, model_par(m), -1);
    end
    m = '1;
    run_one("ones", m, model_par(m), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
